// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: multi-channel 50 Hz hobby-servo PWM bank with
// per-frame slew limiting and frame-aligned pulse width updates.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   enable        output enable (low: pwm low, slew paused)
//   cmd_valid/    target write handshake; ready drops only
//   cmd_ready     in the frame boundary cycle
//   cmd_ch        channel index (out-of-range writes dropped)
//   cmd_pos       8-bit target position
//   pwm           per-channel servo pulses (registered)
//   frame_start   one-cycle pulse in the frame boundary cycle
//   moving        per-channel pos != target
module servo_pwm_bank #(
  parameter int CHANNELS = 5,
  parameter int CLK_HZ   = 50_000_000,
  parameter int FRAME_US = 20000,
  parameter int MIN_US   = 1000,
  parameter int MAX_US   = 2000,
  parameter int STEP     = 4,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CW-1:0]       cmd_ch,
  input  logic [7:0]          cmd_pos,
  output logic [CHANNELS-1:0] pwm,
  output logic                frame_start,
  output logic [CHANNELS-1:0] moving
);

  localparam int DIV  = CLK_HZ / 1_000_000;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int UW   = $clog2(FRAME_US + 1);
  localparam int SPAN = MAX_US - MIN_US;
  localparam int SW   = $clog2(SPAN + 1);
  localparam int MW   = 8 + SW;

  localparam logic [7:0]    STP    = 8'(STEP);
  localparam logic [7:0]    CENTRE = 8'd128;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [UW-1:0] US_MAX  = UW'(FRAME_US - 1);

  // Position -> pulse width in microseconds.
  function automatic logic [UW-1:0] width_of(
    input logic [7:0] p
  );
    logic [MW-1:0] prod;
    prod = MW'(p) * MW'(SPAN);
    return UW'(MIN_US) + UW'(prod >> 8);
  endfunction

  // One slew step of at most STEP toward t (STEP=0: jump).
  function automatic logic [7:0] slew_of(
    input logic [7:0] p,
    input logic [7:0] t
  );
    logic [7:0] d;
    d = (t >= p) ? (t - p) : (p - t);
    if (STEP == 0 || d <= STP) return t;
    else if (t > p)            return p + STP;
    else                       return p - STP;
  endfunction

  localparam logic [UW-1:0] W_RST = width_of(CENTRE);

  logic [PW-1:0] pre_q, pre_d;
  logic [UW-1:0] us_q, us_d;
  logic          fs_q, fs_d;
  logic          arm_q, arm_d;
  logic          pre_wrap, us_wrap, wr;

  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic [7:0]    tgt_q [CHANNELS];
  logic [7:0]    tgt_d [CHANNELS];
  logic [7:0]    pos_q [CHANNELS];
  logic [7:0]    pos_d [CHANNELS];
  logic [UW-1:0] wid_q [CHANNELS];
  logic [UW-1:0] wid_d [CHANNELS];

  assign pre_wrap = (pre_q == PRE_MAX);
  assign us_wrap  = (us_q == US_MAX);

  always_comb begin
    pre_d = pre_wrap ? '0 : pre_q + 1'b1;
    us_d  = us_q;
    if (pre_wrap) us_d = us_wrap ? '0 : us_q + 1'b1;
    fs_d  = pre_wrap && us_wrap;
  end

  // The boundary cycle refuses commands so that the slew at
  // its closing edge always sees a stable target.
  assign cmd_ready   = !fs_q;
  assign frame_start = fs_q;
  assign pwm         = pwm_q;

  assign wr = cmd_valid && cmd_ready &&
              ({1'b0, cmd_ch} < (CW+1)'(CHANNELS));

  // Arm follows enable at the boundary, and drops at once when
  // enable falls so a mid-frame re-enable never emits a stub.
  assign arm_d = fs_q ? enable : (arm_q && enable);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      tgt_d[i] = tgt_q[i];
      pos_d[i] = pos_q[i];
      wid_d[i] = wid_q[i];
      if (wr && cmd_ch == CW'(i)) tgt_d[i] = cmd_pos;
      if (fs_q) begin
        if (enable) pos_d[i] = slew_of(pos_q[i], tgt_q[i]);
        wid_d[i] = width_of(pos_d[i]);
      end
      // In the boundary cycle us_q is 0, below any width, so
      // using the old width there cannot clip the pulse.
      pwm_d[i]  = arm_d && (us_q < wid_q[i]);
      moving[i] = (pos_q[i] != tgt_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      us_q  <= '0;
      fs_q  <= 1'b0;
      arm_q <= 1'b0;
      pwm_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        tgt_q[i] <= CENTRE;
        pos_q[i] <= CENTRE;
        wid_q[i] <= W_RST;
      end
    end else begin
      pre_q <= pre_d;
      us_q  <= us_d;
      fs_q  <= fs_d;
      arm_q <= arm_d;
      pwm_q <= pwm_d;
      for (int i = 0; i < CHANNELS; i++) begin
        tgt_q[i] <= tgt_d[i];
        pos_q[i] <= pos_d[i];
        wid_q[i] <= wid_d[i];
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// tb_servo_pwm_bank: directed frame-locked bench, two banks
// (STEP=4 and STEP=0) sharing clock and reset.
module tb_servo_pwm_bank;

  localparam int CH  = 5;
  localparam int DIV = 2;
  localparam int FUS = 2100;
  localparam int FC  = FUS * DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en_a, en_b, cv_a, cv_b;
  logic [2:0] ch_a, ch_b;
  logic [7:0] pos_a, pos_b;
  logic rdy_a, rdy_b, fs_a, fs_b;
  logic [CH-1:0] pwm_a, pwm_b, mv_a, mv_b;

  servo_pwm_bank #(
    .CHANNELS(CH), .CLK_HZ(DIV * 1_000_000),
    .FRAME_US(FUS), .MIN_US(1000), .MAX_US(2000),
    .STEP(4)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a),
    .cmd_valid(cv_a), .cmd_ready(rdy_a),
    .cmd_ch(ch_a), .cmd_pos(pos_a), .pwm(pwm_a),
    .frame_start(fs_a), .moving(mv_a)
  );

  servo_pwm_bank #(
    .CHANNELS(CH), .CLK_HZ(DIV * 1_000_000),
    .FRAME_US(FUS), .MIN_US(1000), .MAX_US(2000),
    .STEP(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b),
    .cmd_valid(cv_b), .cmd_ready(rdy_b),
    .cmd_ch(ch_b), .cmd_pos(pos_b), .pwm(pwm_b),
    .frame_start(fs_b), .moving(mv_b)
  );

  int total = 0;
  int bad   = 0;
  int wa [CH];
  int wb [CH];
  int ra [CH];
  int rb [CH];
  int pre_hi, pre_fs;

  task automatic chk(input string tag, input int got,
                     input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called at the boundary negedge; samples the rest of the
  // frame and records high-cycle counts and first-high index.
  task automatic scan();
    for (int i = 0; i < CH; i++) begin
      wa[i] = 0; wb[i] = 0; ra[i] = 0; rb[i] = 0;
    end
    for (int k = 1; k < FC; k++) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) begin
        if (pwm_a[i]) begin
          if (wa[i] == 0) ra[i] = k;
          wa[i]++;
        end
        if (pwm_b[i]) begin
          if (wb[i] == 0) rb[i] = k;
          wb[i]++;
        end
      end
    end
  endtask

  task automatic next_b(input string tag);
    @(negedge clk);
    chk(tag, int'({fs_b, fs_a}), 3);
  endtask

  task automatic pre_frame();
    pre_hi = 0;
    pre_fs = 0;
    for (int k = 1; k < FC; k++) begin
      @(negedge clk);
      if (|pwm_a || |pwm_b) pre_hi++;
      if (fs_a || fs_b) pre_fs++;
    end
    chk("f0_hi", pre_hi, 0);
    chk("f0_fs", pre_fs, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 1'b1; en_b = 1'b1;
    cv_a = 1'b0; cv_b = 1'b0;
    ch_a = '0; ch_b = '0;
    pos_a = '0; pos_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'({pwm_b, pwm_a}), 0);
    chk("rst_fs", int'(fs_a | fs_b), 0);
    chk("rst_rdy", int'(rdy_a & rdy_b), 1);
    chk("rst_mv", int'({mv_b, mv_a}), 0);
    rst_n = 1'b1;
    pre_frame();

    // Frame 1: centre pulses, then targets written.
    next_b("b1");
    fork
      scan();
      begin
        repeat (10) @(negedge clk);
        cv_a = 1'b1; ch_a = 3'd0; pos_a = 8'd140;
        cv_b = 1'b1; ch_b = 3'd2; pos_b = 8'd255;
        @(negedge clk);
        cv_a = 1'b0; cv_b = 1'b0;
        chk("wr_mv_a", int'(mv_a), 5'b00001);
        chk("wr_mv_b", int'(mv_b), 5'b00100);
      end
    join
    for (int i = 0; i < CH; i++) chk("f1_wa", wa[i], 3000);
    chk("f1_ra0", ra[0], 1);
    chk("f1_wb2", wb[2], 3000);

    // Frame 2: first slew step / jump.
    next_b("b2");
    fork
      scan();
      begin
        @(negedge clk);
        chk("b2_mv_a", int'(mv_a), 5'b00001);
        chk("b2_mv_b", int'(mv_b), 0);
      end
    join
    chk("f2_wa0", wa[0], 3030);
    chk("f2_ra0", ra[0], 1);
    chk("f2_wb2", wb[2], 3992);
    chk("f2_rb2", rb[2], 1);
    chk("f2_wb0", wb[0], 3000);
    chk("f2_wa1", wa[1], 3000);

    // Frame 3: write during boundary stalls; bad channel.
    next_b("b3");
    fork
      scan();
      begin
        cv_a = 1'b1; ch_a = 3'd1; pos_a = 8'd100;
        chk("bnd_rdy", int'(rdy_a), 0);
        @(negedge clk);
        chk("bnd1_rdy", int'(rdy_a), 1);
        chk("bnd1_mv", int'(mv_a), 5'b00001);
        @(negedge clk);
        cv_a = 1'b0;
        chk("bnd2_mv", int'(mv_a), 5'b00011);
        repeat (20) @(negedge clk);
        cv_a = 1'b1; ch_a = 3'd7; pos_a = 8'd0;
        @(negedge clk);
        cv_a = 1'b0;
        chk("ch7_mv", int'(mv_a), 5'b00011);
        chk("ch7_rdy", int'(rdy_a), 1);
      end
    join
    chk("f3_wa0", wa[0], 3062);
    chk("f3_wa1", wa[1], 3000);

    // Frame 4: ch0 settles, ch1 starts down.
    next_b("b4");
    fork
      scan();
      begin
        @(negedge clk);
        chk("b4_mv", int'(mv_a), 5'b00010);
      end
    join
    chk("f4_wa0", wa[0], 3092);
    chk("f4_wa1", wa[1], 2968);
    chk("f4_wa2", wa[2], 3000);
    chk("f4_wa4", wa[4], 3000);

    // Frame 5: enable drops mid-pulse.
    next_b("b5");
    fork
      scan();
      begin
        repeat (1000) @(negedge clk);
        en_a = 1'b0;
        @(negedge clk);
        chk("dis_pwm", int'(pwm_a), 0);
      end
    join
    chk("f5_wa0", wa[0], 1000);
    chk("f5_wa1", wa[1], 1000);
    chk("f5_wb0", wb[0], 3000);

    // Frame 6: disarmed; re-enabled mid-frame stays low.
    next_b("b6");
    fork
      scan();
      begin
        repeat (2000) @(negedge clk);
        en_a = 1'b1;
      end
    join
    chk("f6_hi", wa[0] + wa[1] + wa[2] + wa[3] + wa[4], 0);

    // Frame 7: full pulses again; ch1 slew resumed from 120.
    next_b("b7");
    scan();
    chk("f7_wa1", wa[1], 2906);
    chk("f7_ra1", ra[1], 1);
    chk("f7_wa0", wa[0], 3092);
    chk("f7_wa3", wa[3], 3000);

    // Frame 8: async reset mid-pulse.
    next_b("b8");
    repeat (500) @(negedge clk);
    chk("mid_pwm", int'(pwm_a), 5'h1f);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_pwm", int'({pwm_b, pwm_a}), 0);
    chk("arst_mv", int'({mv_b, mv_a}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pre_frame();
    next_b("rb1");
    scan();
    for (int i = 0; i < CH; i++) begin
      chk("rs_wa", wa[i], 3000);
      chk("rs_wb", wb[i], 3000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
